// File: rtl/ternary_trit_feeder_pkg.sv
// Shared definitions for the ternary trit feeder: trit codes, FSM states and defaults.
package ternary_pkg;

    localparam int TPW_DEF   = 16;
    localparam int LEN_W_DEF = 16;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;
    localparam logic [1:0] TRIT_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DONE   = 2'b10
    } feeder_state_e;

    function automatic logic trit_is_bad(input logic [1:0] trit);
        return (trit == TRIT_BAD);
    endfunction

endpackage

// File: rtl/ternary_trit_feeder_buffer.sv
// One-word trit buffer per stream: holds the packed word, tracks words still owed
// for the run, generates ready and presents the trit selected by the shared index.
module trit_word_buffer
    import ternary_pkg::*;
#(
    parameter int TPW   = TPW_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int IDX_W = $clog2(TPW)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [LEN_W-1:0]   word_count,
    input  logic               stream,
    input  logic               fire_clears_buffer,
    input  logic [IDX_W-1:0]   idx,
    input  logic               in_valid,
    input  logic [2*TPW-1:0]   in_data,
    output logic               in_ready,
    output logic               buf_valid,
    output logic [1:0]         trit,
    output logic               illegal
);

    logic [2*TPW-1:0] word_r;
    logic             valid_r;
    logic [LEN_W-1:0] words_left_r;
    logic [1:0]       sel_s;
    logic             accept_s;

    // Ready may rise while the last trit of the held word is consumed, giving back-to-back words.
    always_comb begin
        sel_s    = word_r[{idx, 1'b0} +: 2];
        illegal  = trit_is_bad(sel_s);
        in_ready = stream && (words_left_r != {LEN_W{1'b0}}) && (!valid_r || fire_clears_buffer);
        accept_s = in_valid && in_ready;
        if (illegal) begin
            trit = TRIT_ZERO;
        end else begin
            trit = sel_s;
        end
    end

    // Word register, valid bit and owed-word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r       <= {(2*TPW){1'b0}};
            valid_r      <= 1'b0;
            words_left_r <= {LEN_W{1'b0}};
        end else if (load) begin
            valid_r      <= 1'b0;
            words_left_r <= word_count;
        end else if (accept_s) begin
            word_r       <= in_data;
            valid_r      <= 1'b1;
            words_left_r <= words_left_r - LEN_W'(1);
        end else if (fire_clears_buffer) begin
            valid_r      <= 1'b0;
        end
    end

    assign buf_valid = valid_r;

endmodule

// File: rtl/ternary_trit_feeder.sv
// Feeds one ternary ALU lane: unpacks weight and activation word streams in lockstep
// and emits one trit pair per enabled cycle for a programmed count.
module ternary_trit_feeder
    import ternary_pkg::*;
#(
    parameter int TPW   = TPW_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   length,
    input  logic               w_valid,
    input  logic [2*TPW-1:0]   w_data,
    output logic               w_ready,
    input  logic               x_valid,
    input  logic [2*TPW-1:0]   x_data,
    output logic               x_ready,
    output logic [1:0]         weight,
    output logic [1:0]         trit_in,
    output logic               lane_enable,
    output logic               busy,
    output logic               done,
    output logic               code_error
);

    localparam int IDX_W = $clog2(TPW);

    feeder_state_e    state_r, state_s;
    logic [IDX_W-1:0] idx_r;
    logic [LEN_W-1:0] remaining_r;
    logic [1:0]       weight_r, trit_in_r;
    logic             lane_enable_r, busy_r, done_r, code_error_r;

    logic             w_buf_valid_s, x_buf_valid_s;
    logic [1:0]       w_trit_s, x_trit_s;
    logic             w_illegal_s, x_illegal_s;
    logic             stream_s, fire_s, fire_clears_s, start_run_s, load_s;
    logic [LEN_W:0]   word_sum_s;
    logic [LEN_W-1:0] word_count_s;

    // Fire/clear decode and per-run word count (ceil of length over trits per word).
    always_comb begin
        stream_s      = (state_r == STREAM);
        fire_s        = stream_s && w_buf_valid_s && x_buf_valid_s && (remaining_r != {LEN_W{1'b0}});
        fire_clears_s = fire_s && ((idx_r == IDX_W'(TPW - 1)) || (remaining_r == LEN_W'(1)));
        start_run_s   = (state_r == IDLE) && start;
        load_s        = start_run_s && (length != {LEN_W{1'b0}});
        word_sum_s    = {1'b0, length} + (LEN_W + 1)'(TPW - 1);
        word_count_s  = LEN_W'(word_sum_s / (LEN_W + 1)'(TPW));
    end

    trit_word_buffer #(.TPW(TPW), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_w_buf (
        .clk                (clk),
        .reset              (reset),
        .load               (load_s),
        .word_count         (word_count_s),
        .stream             (stream_s),
        .fire_clears_buffer (fire_clears_s),
        .idx                (idx_r),
        .in_valid           (w_valid),
        .in_data            (w_data),
        .in_ready           (w_ready),
        .buf_valid          (w_buf_valid_s),
        .trit               (w_trit_s),
        .illegal            (w_illegal_s)
    );

    trit_word_buffer #(.TPW(TPW), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_x_buf (
        .clk                (clk),
        .reset              (reset),
        .load               (load_s),
        .word_count         (word_count_s),
        .stream             (stream_s),
        .fire_clears_buffer (fire_clears_s),
        .idx                (idx_r),
        .in_valid           (x_valid),
        .in_data            (x_data),
        .in_ready           (x_ready),
        .buf_valid          (x_buf_valid_s),
        .trit               (x_trit_s),
        .illegal            (x_illegal_s)
    );

    // Next-state logic; DONE follows the cycle in which the final pair is presented.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length == {LEN_W{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = STREAM;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (remaining_r == {LEN_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = STREAM;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, counters and registered lane outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            idx_r         <= {IDX_W{1'b0}};
            remaining_r   <= {LEN_W{1'b0}};
            weight_r      <= TRIT_ZERO;
            trit_in_r     <= TRIT_ZERO;
            lane_enable_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            code_error_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            busy_r        <= (state_s == STREAM);
            done_r        <= (state_s == DONE);
            lane_enable_r <= fire_s;
            if (fire_s) begin
                weight_r  <= w_trit_s;
                trit_in_r <= x_trit_s;
            end
            if (start_run_s) begin
                code_error_r <= 1'b0;
            end else if (fire_s && (w_illegal_s || x_illegal_s)) begin
                code_error_r <= 1'b1;
            end
            if (load_s) begin
                remaining_r <= length;
                idx_r       <= {IDX_W{1'b0}};
            end else if (fire_s) begin
                remaining_r <= remaining_r - LEN_W'(1);
                idx_r       <= fire_clears_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            end
        end
    end

    assign weight      = weight_r;
    assign trit_in     = trit_in_r;
    assign lane_enable = lane_enable_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign code_error  = code_error_r;

endmodule

// File: tb/tb_ternary_trit_feeder.sv
// Directed bench for ternary_trit_feeder: each scenario task drives a run and checks
// enable timing, captured trits, word acceptance and status flags against hand values.
module tb_ternary_trit_feeder;

    logic        clk = 1'b0;
    logic        reset, start, w_valid, x_valid;
    logic [15:0] length;
    logic [31:0] w_data, x_data;
    logic        w_ready, x_ready, lane_enable, busy, done, code_error;
    logic [1:0]  weight, trit_in;

    int errors = 0;
    int checks = 0;

    logic [31:0] w_words [0:3];
    logic [31:0] x_words [0:3];
    int          nw;
    logic [1:0]  cap_w [0:63];
    logic [1:0]  cap_x [0:63];
    int en_cnt, first_en, last_en, done_c, w_acc, x_acc, w_ready_wait, ready_seen;

    always #5 clk = ~clk;

    ternary_trit_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .length      (length),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .x_valid     (x_valid),
        .x_data      (x_data),
        .x_ready     (x_ready),
        .weight      (weight),
        .trit_in     (trit_in),
        .lane_enable (lane_enable),
        .busy        (busy),
        .done        (done),
        .code_error  (code_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a run and drives both word streams; cycle 0 is the first cycle after start is taken.
    task automatic run(input int len, input int x_delay, input int rst_at);
        en_cnt = 0; first_en = -1; last_en = -1; done_c = -1;
        w_acc = 0; x_acc = 0; w_ready_wait = 0; ready_seen = 0;
        length = 16'(len);
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (w_ready || x_ready) ready_seen++;
            if (lane_enable) begin
                if (en_cnt < 64) begin
                    cap_w[en_cnt] = weight;
                    cap_x[en_cnt] = trit_in;
                end
                if (first_en < 0) first_en = c;
                last_en = c;
                en_cnt++;
            end
            if (done) begin
                done_c = c;
                break;
            end
            if (rst_at >= 0 && en_cnt == rst_at) begin
                w_valid = 1'b0;
                x_valid = 1'b0;
                reset   = 1'b1;
                step();
                break;
            end
            w_valid = (w_acc < nw);
            w_data  = (w_acc < 4) ? w_words[w_acc] : 32'h0;
            x_valid = (c >= x_delay) && (x_acc < nw);
            x_data  = (x_acc < 4) ? x_words[x_acc] : 32'h0;
            @(negedge clk);
            if (w_acc > 0 && x_acc == 0 && w_ready) w_ready_wait++;
            if (w_valid && w_ready) w_acc++;
            if (x_valid && x_ready) x_acc++;
            step();
        end
        w_valid = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({weight, trit_in, lane_enable, busy, done, code_error, w_ready, x_ready} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {weight, trit_in, lane_enable, busy, done, code_error, w_ready, x_ready});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        w_words[0] = 32'h0000_0099; x_words[0] = 32'h0000_0055; nw = 1;
        run(4, 0, -1);
        checks++; if (en_cnt !== 4)   begin errors++; $display("FAIL basic_count: got %0d expected 4", en_cnt); end
        checks++; if (first_en !== 2) begin errors++; $display("FAIL basic_first: got %0d expected 2", first_en); end
        checks++; if (done_c !== 6)   begin errors++; $display("FAIL basic_done: got %0d expected 6", done_c); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
        checks++; if (w_acc !== 1 || x_acc !== 1) begin errors++; $display("FAIL basic_words: got %0d/%0d expected 1/1", w_acc, x_acc); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_w[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) || cap_x[k] !== 2'b01) begin
                errors++;
                $display("FAIL basic_pair%0d: got w=%b x=%b", k, cap_w[k], cap_x[k]);
            end
        end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_multi_word();
        w_words[0] = 32'h0; w_words[1] = 32'h0000_0001; w_words[2] = 32'h0;
        x_words[0] = 32'h0; x_words[1] = 32'h0;         x_words[2] = 32'h0;
        nw = 3;
        run(20, 0, -1);
        checks++; if (en_cnt !== 20) begin errors++; $display("FAIL multi_count: got %0d expected 20", en_cnt); end
        checks++; if (last_en - first_en !== 19) begin errors++; $display("FAIL multi_gap: got span %0d expected 19", last_en - first_en); end
        checks++; if (done_c !== last_en + 1) begin errors++; $display("FAIL multi_done: got %0d expected %0d", done_c, last_en + 1); end
        checks++; if (w_acc !== 2 || x_acc !== 2) begin errors++; $display("FAIL multi_words: got %0d/%0d expected 2/2", w_acc, x_acc); end
        checks++;
        if (cap_w[16] !== 2'b01 || cap_w[15] !== 2'b00 || cap_w[17] !== 2'b00) begin
            errors++;
            $display("FAIL multi_pair16: got %b %b %b expected 00 01 00", cap_w[15], cap_w[16], cap_w[17]);
        end
        step();
    endtask

    task automatic test_skew();
        w_words[0] = 32'h0000_0099; x_words[0] = 32'h0000_0055; nw = 1;
        run(4, 5, -1);
        checks++; if (first_en !== 7) begin errors++; $display("FAIL skew_first: got %0d expected 7", first_en); end
        checks++; if (w_ready_wait !== 0) begin errors++; $display("FAIL skew_w_ready: got %0d ready cycles expected 0", w_ready_wait); end
        checks++; if (en_cnt !== 4 || done_c !== 11) begin errors++; $display("FAIL skew_run: got %0d enables done %0d expected 4/11", en_cnt, done_c); end
        step();
    endtask

    task automatic test_len_zero();
        w_words[0] = 32'h0000_0099; x_words[0] = 32'h0000_0055; nw = 1;
        run(0, 0, -1);
        checks++; if (done_c !== 0) begin errors++; $display("FAIL len0_done: got %0d expected 0", done_c); end
        checks++;
        if (en_cnt !== 0 || ready_seen !== 0 || w_acc !== 0) begin
            errors++;
            $display("FAIL len0_quiet: got en=%0d ready=%0d acc=%0d expected 0/0/0", en_cnt, ready_seen, w_acc);
        end
        step();
    endtask

    task automatic test_illegal();
        w_words[0] = 32'h0000_0003; x_words[0] = 32'h0000_0001; nw = 1;
        run(1, 0, -1);
        checks++;
        if (en_cnt !== 1 || cap_w[0] !== 2'b00 || cap_x[0] !== 2'b01) begin
            errors++;
            $display("FAIL illegal_pair: got en=%0d w=%b x=%b expected 1/00/01", en_cnt, cap_w[0], cap_x[0]);
        end
        step();
        step();
        checks++; if (code_error !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected 1", code_error); end
        w_words[0] = 32'h0000_0099; x_words[0] = 32'h0000_0055;
        run(4, 0, -1);
        checks++; if (code_error !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b expected 0", code_error); end
        step();
    endtask

    task automatic test_reset_midrun();
        w_words[0] = 32'h9999_9999; x_words[0] = 32'h5555_5555; nw = 1;
        run(16, 0, 7);
        checks++;
        if ({weight, trit_in, lane_enable, busy, done, code_error, w_ready, x_ready} !== 10'b0) begin
            errors++;
            $display("FAIL midrun_reset: got %b expected 0", {weight, trit_in, lane_enable, busy, done, code_error, w_ready, x_ready});
        end
        reset = 1'b0;
        step();
        run(16, 0, -1);
        checks++; if (en_cnt !== 16 || done_c !== 18) begin errors++; $display("FAIL midrun_fresh: got %0d enables done %0d expected 16/18", en_cnt, done_c); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (cap_w[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) || cap_x[k] !== 2'b01) begin
                errors++;
                $display("FAIL midrun_pair%0d: got w=%b x=%b", k, cap_w[k], cap_x[k]);
            end
        end
        step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; length = 16'h0;
        w_valid = 1'b0; x_valid = 1'b0; w_data = 32'h0; x_data = 32'h0;
        nw = 0;
        test_reset();
        test_basic();
        test_multi_word();
        test_skew();
        test_len_zero();
        test_illegal();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
